// File: rtl/etapa_decodificacion.sv
// Decode stage: buffers fetched instruction words in a small FIFO and
// presents one registered, field-split instruction at a time to execute.
module etapa_decodificacion #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              dec_valid,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rn,
  output logic [3:0]        rd,
  output logic [11:0]       src2,
  output logic              imm,
  output logic              is_branch,
  output logic              is_mem,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] word_q;

  logic full;
  logic empty;
  logic push;
  logic load;
  logic pop;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

  // Readiness comes from registered occupancy only, so a same-cycle pop
  // never frees a slot for a push.
  assign instr_ready = reset & ~full;
  assign push        = instr_valid & instr_ready & ~flush;
  assign load        = ~flush & (~dec_valid | ~stall);
  assign pop         = load & ~empty;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr_in;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  // Decode output register: loads the FIFO head when downstream can take
  // it; an empty FIFO leaves a bubble but keeps the last fields visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q    <= '0;
      dec_valid <= 1'b0;
    end else if (flush) begin
      word_q    <= '0;
      dec_valid <= 1'b0;
    end else if (load) begin
      if (pop) begin
        word_q    <= mem[rd_ptr];
        dec_valid <= 1'b1;
      end else begin
        dec_valid <= 1'b0;
      end
    end
  end

  // Counts instructions actually handed to execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (dec_valid && !stall && !flush) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  // Fields are slices of the registered word, so flags clear with it.
  assign cond      = word_q[31:28];
  assign op        = word_q[27:26];
  assign funct     = word_q[25:20];
  assign rn        = word_q[19:16];
  assign rd        = word_q[15:12];
  assign src2      = word_q[11:0];
  assign imm       = word_q[25];
  assign is_branch = (word_q[27:26] == 2'b10);
  assign is_mem    = (word_q[27:26] == 2'b01);
  assign illegal   = (word_q[27:26] == 2'b11);

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Directed bench for etapa_decodificacion.
module tb_etapa_decodificacion;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic        dec_valid;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] src2;
  logic        imm;
  logic        is_branch;
  logic        is_mem;
  logic        illegal;
  logic [15:0] instr_count;

  logic [31:0] dw;
  int          compared;
  int          mismatched;

  etapa_decodificacion #(
    .DATA_W(32),
    .DEPTH (2),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .stall      (stall),
    .flush      (flush),
    .dec_valid  (dec_valid),
    .cond       (cond),
    .op         (op),
    .funct      (funct),
    .rn         (rn),
    .rd         (rd),
    .src2       (src2),
    .imm        (imm),
    .is_branch  (is_branch),
    .is_mem     (is_mem),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  assign dw = {cond, op, funct, rn, rd, src2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    step();

    // Reset state
    check("rst_dec_valid", dec_valid, 0);
    check("rst_ready", instr_ready, 0);
    check("rst_count", instr_count, 0);
    check("rst_word", dw, 0);
    check("rst_flags", {imm, is_branch, is_mem, illegal}, 0);
    reset = 1'b1;
    #1;
    check("rel_ready", instr_ready, 1);

    // Single data-processing instruction, one-cycle latency
    @(negedge clk);
    instr_in = 32'hE2801005; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("t1_no_bypass", dec_valid, 0);
    step();
    check("t1_valid", dec_valid, 1);
    check("t1_cond", cond, 4'hE);
    check("t1_op", op, 0);
    check("t1_funct", funct, 6'h28);
    check("t1_rn", rn, 0);
    check("t1_rd", rd, 1);
    check("t1_src2", src2, 12'h005);
    check("t1_flags", {imm, is_branch, is_mem, illegal}, 4'b1000);
    step();
    check("t1_bubble", dec_valid, 0);
    check("t1_count", instr_count, 1);
    check("t1_hold", dw, 32'hE2801005);

    // Branch then memory op, back to back
    instr_in = 32'hEA000002; instr_valid = 1'b1;
    step();
    instr_in = 32'hE5912000;
    step();
    instr_valid = 1'b0;
    check("t2_b_valid", dec_valid, 1);
    check("t2_b_op", op, 2);
    check("t2_b_funct", funct, 6'h20);
    check("t2_b_flags", {imm, is_branch, is_mem, illegal}, 4'b1100);
    step();
    check("t2_m_valid", dec_valid, 1);
    check("t2_m_word", dw, 32'hE5912000);
    check("t2_m_funct", funct, 6'h19);
    check("t2_m_rn_rd", {rn, rd}, 8'h12);
    check("t2_m_flags", {imm, is_branch, is_mem, illegal}, 4'b0010);
    check("t2_count", instr_count, 2);
    step();
    check("t2_bubble", dec_valid, 0);
    check("t2_count_after", instr_count, 3);

    // Stall fills the FIFO; release drains in order
    stall = 1'b1; instr_valid = 1'b1; instr_in = 32'hE0811002;
    step();
    check("t3_bubble_stall", dec_valid, 0);
    instr_in = 32'hE0822003;
    step();
    check("t3_w0", dw, 32'hE0811002);
    check("t3_w0_valid", dec_valid, 1);
    check("t3_ready_1", instr_ready, 1);
    instr_in = 32'hE0833004;
    step();
    check("t3_ready_full", instr_ready, 0);
    check("t3_w0_frozen", dw, 32'hE0811002);
    instr_in = 32'hE0844005;
    step();
    step();
    check("t3_w0_still", dw, 32'hE0811002);
    check("t3_ready_still0", instr_ready, 0);
    check("t3_count_stalled", instr_count, 3);
    stall = 1'b0;
    step();
    check("t3_w1", dw, 32'hE0822003);
    check("t3_count_w0", instr_count, 4);
    check("t3_ready_back", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    check("t3_w2", dw, 32'hE0833004);
    step();
    check("t3_w3", dw, 32'hE0844005);
    check("t3_w3_valid", dec_valid, 1);
    check("t3_count_w3", instr_count, 6);
    step();
    check("t3_drained", dec_valid, 0);
    check("t3_count_end", instr_count, 7);

    // Flush with two buffered and a live output
    stall = 1'b1; instr_valid = 1'b1; instr_in = 32'hE1A01001;
    step();
    instr_in = 32'hE1A02002;
    step();
    instr_in = 32'hE1A03003;
    step();
    check("t4_pre_full", instr_ready, 0);
    check("t4_pre_valid", dec_valid, 1);
    flush = 1'b1; instr_in = 32'hE1A04004;
    step();
    check("t4_valid", dec_valid, 0);
    check("t4_word", dw, 0);
    check("t4_flags", {imm, is_branch, is_mem, illegal}, 0);
    check("t4_ready", instr_ready, 1);
    check("t4_count", instr_count, 7);
    instr_in = 32'hE1A05005;
    step();
    flush = 1'b0; stall = 1'b0; instr_valid = 1'b0;
    step();
    check("t4_push_dropped", dec_valid, 0);
    step();
    check("t4_still_empty", dec_valid, 0);
    check("t4_count_after", instr_count, 7);

    // Illegal opcode is still delivered
    instr_in = 32'hFC000000; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("t5_valid", dec_valid, 1);
    check("t5_cond", cond, 4'hF);
    check("t5_flags", {imm, is_branch, is_mem, illegal}, 4'b0001);
    step();
    check("t5_count", instr_count, 8);

    // Counter wrap under continuous streaming
    reset = 1'b0;
    #1;
    check("t6_rst_count", instr_count, 0);
    @(negedge clk);
    reset = 1'b1;
    instr_in = 32'hE3A00001; instr_valid = 1'b1;
    repeat (65537) step();
    check("t6_count_max", instr_count, 16'hFFFF);
    check("t6_stream_valid", dec_valid, 1);
    step();
    check("t6_count_wrap", instr_count, 0);
    repeat (3) step();
    check("t6_count_3", instr_count, 3);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_valid", dec_valid, 0);
    check("t6_async_count", instr_count, 0);
    check("t6_async_ready", instr_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rel_ready", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    step();
    check("t6_first_after", dec_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/etapa_decodificacion.md
Name: etapa_decodificacion

Overview:
- Fetch/decode stage directly downstream of modulo_instrucciones; consumes its 32-bit instruction word each clock.
- Buffers instructions in a small FIFO so upstream fetch is never lost while the execute stage stalls.
- Splits each word into ARM-style fields and presents them in a registered decode output with valid/stall/flush control.

Parameters:
DATA_W, 32, instruction width (fixed field map below assumes 32)
DEPTH, 2, FIFO entries (power of 2, >=2)
CNT_W, 16, width of delivered-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
instr_in  in  DATA_W  instruction word from modulo_instrucciones
instr_valid  in  1  instr_in is valid this cycle
instr_ready  out  1  FIFO can accept; push = instr_valid & instr_ready
stall  in  1  downstream cannot take decode output; hold it
flush  in  1  synchronous discard of all buffered/decoded instructions
dec_valid  out  1  decode outputs hold a live instruction
cond  out  4  instr[31:28]
op  out  2  instr[27:26]
funct  out  6  instr[25:20]
rn  out  4  instr[19:16]
rd  out  4  instr[15:12]
src2  out  12  instr[11:0]
imm  out  1  funct[5]
is_branch  out  1  op == 2'b10
is_mem  out  1  op == 2'b01
illegal  out  1  op == 2'b11
instr_count  out  CNT_W  instructions consumed downstream

Behaviour:
- Reset (reset=0, async): FIFO pointers/occupancy 0, dec_valid 0, all field outputs and flags 0, instr_count 0, instr_ready 0 while reset held.
- instr_ready = reset & (occupancy != DEPTH), combinational from registered occupancy; no push when full even if a pop occurs that cycle.
- Load condition: load = !flush & (!dec_valid | !stall). On load: if FIFO non-empty, pop head into output register, decode fields, dec_valid<=1; if empty, dec_valid<=0, fields hold last values.
- Latency: word pushed at edge N appears with dec_valid=1 after edge N+1 (FIFO empty, no stall). No combinational bypass input-to-output.
- Simultaneous push and pop: occupancy unchanged; pointers both advance modulo DEPTH (wrap-around).
- Stall with dec_valid=1: all decode outputs frozen; FIFO keeps accepting until full, then instr_ready=0.
- Stall with dec_valid=0: ignored (bubble is filled).
- Flush: highest priority over push, pop, stall. Next edge: occupancy 0, pointers 0, dec_valid 0, fields and flags cleared to 0; concurrent push discarded. instr_count not affected.
- Decode is purely field extraction plus flags; illegal (op 11) still delivered with dec_valid=1, is_branch=is_mem=0.
- instr_count increments on every edge with dec_valid & !stall & !flush; wraps 2^CNT_W-1 -> 0.
- Reset asserted mid-operation: immediate clear of all state regardless of clk; after release, first push allowed on next edge.

Test Plan:
- Reset release, push 0xE2801005 once, stall=0 -> one cycle later dec_valid=1, cond=0xE, op=0, funct=0x28, rn=0, rd=1, src2=0x005, imm=1, flags 0; next cycle dec_valid=0, instr_count=1.
- Push 0xEA000002 then 0xE5912000 back-to-back -> first: op=2, funct=0x20, is_branch=1; second: op=1, funct=0x19, rn=1, rd=2, is_mem=1; order preserved, instr_count=2.
- Hold stall=1, push 4 words continuously (DEPTH=2) -> output holds word0, FIFO takes words 1-2, instr_ready=0 on 4th, instr_valid held; release stall -> words 1,2,3 emerge in order, none lost or duplicated.
- With 2 buffered and dec_valid=1, assert flush with concurrent push -> next cycle dec_valid=0, all fields 0, instr_ready=1, pushed word absent from later output; instr_count unchanged.
- Push 0xFC000000 -> dec_valid=1, illegal=1, is_branch=0, is_mem=0.
- Preload instr_count to 0xFFFF via 65535 consumes, consume one more -> instr_count=0; pulse reset low mid-stream between edges -> dec_valid and instr_count 0 immediately.
